// File: rtl/dht_sample_manager_if.sv
// Reader-side handshake and published sample bus of the DHT11 sample manager.
// master = the manager, slave = reader/display environment.
interface dht_sample_manager_if;
  logic        EN;
  logic        RDR_START;
  logic        RDR_DONE;
  logic [39:0] RDR_FRAME;
  logic [7:0]  HUM_INT;
  logic [7:0]  HUM_FRAC;
  logic [7:0]  TEMP_INT;
  logic [7:0]  TEMP_FRAC;
  logic        DATA_VALID;
  logic        NEW_SAMPLE;
  logic        CRC_ERR;
  logic        SENSOR_FAIL;
  logic [7:0]  ERR_CNT;

  modport master (
    input  EN, RDR_DONE, RDR_FRAME,
    output RDR_START, HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC,
           DATA_VALID, NEW_SAMPLE, CRC_ERR, SENSOR_FAIL, ERR_CNT
  );

  modport slave (
    output EN, RDR_DONE, RDR_FRAME,
    input  RDR_START, HUM_INT, HUM_FRAC, TEMP_INT, TEMP_FRAC,
           DATA_VALID, NEW_SAMPLE, CRC_ERR, SENSOR_FAIL, ERR_CNT
  );
endinterface

// File: rtl/dht_sample_manager.sv
// Periodic DHT11 read scheduler: captures the reader frame, checks the byte-sum
// checksum, publishes last-good bytes and retries / flags sensor failure.
module dht_sample_manager #(
  parameter int PERIOD_CYC    = 200_000_000,
  parameter int TIMEOUT_CYC   = 10_000_000,
  parameter int RETRY_GAP_CYC = 100_000_000,
  parameter int MAX_RETRY     = 3
) (
  input  logic CLK,
  input  logic RST,
  dht_sample_manager_if.master bus
);
  localparam int CNT_MAX = (PERIOD_CYC > TIMEOUT_CYC) ?
                           ((PERIOD_CYC > RETRY_GAP_CYC) ? PERIOD_CYC : RETRY_GAP_CYC) :
                           ((TIMEOUT_CYC > RETRY_GAP_CYC) ? TIMEOUT_CYC : RETRY_GAP_CYC);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_PERIOD, START, WAIT_DONE, CHECK, RETRY_GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic [39:0]      frame_q;
  logic [7:0]       sum;
  logic             sum_ok, timeout, fail;

  always_comb begin
    sum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    sum_ok  = (sum == frame_q[7:0]);
    // a DONE on the last timeout cycle still counts as a response
    timeout = (state == WAIT_DONE) && !bus.RDR_DONE && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    fail    = timeout || ((state == CHECK) && !sum_ok);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= IDLE;
      cnt             <= '0;
      retry_cnt       <= '0;
      frame_q         <= '0;
      bus.RDR_START   <= 1'b0;
      bus.HUM_INT     <= '0;
      bus.HUM_FRAC    <= '0;
      bus.TEMP_INT    <= '0;
      bus.TEMP_FRAC   <= '0;
      bus.DATA_VALID  <= 1'b0;
      bus.NEW_SAMPLE  <= 1'b0;
      bus.CRC_ERR     <= 1'b0;
      bus.SENSOR_FAIL <= 1'b0;
      bus.ERR_CNT     <= '0;
    end else begin
      bus.RDR_START  <= 1'b0;
      bus.NEW_SAMPLE <= 1'b0;
      bus.CRC_ERR    <= 1'b0;
      if (!bus.EN) begin
        // published bytes, flags and ERR_CNT deliberately hold across disable
        state     <= IDLE;
        cnt       <= '0;
        retry_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT_PERIOD;
          end
          WAIT_PERIOD: begin
            if (cnt == CNT_W'(PERIOD_CYC - 1)) begin
              cnt           <= '0;
              state         <= START;
              bus.RDR_START <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          START: begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (bus.RDR_DONE) begin
              frame_q <= bus.RDR_FRAME;
              state   <= CHECK;
            end else if (!timeout) begin
              cnt <= cnt + 1'b1;
            end
          end
          CHECK: begin
            if (sum_ok) begin
              bus.HUM_INT     <= frame_q[39:32];
              bus.HUM_FRAC    <= frame_q[31:24];
              bus.TEMP_INT    <= frame_q[23:16];
              bus.TEMP_FRAC   <= frame_q[15:8];
              bus.DATA_VALID  <= 1'b1;
              bus.NEW_SAMPLE  <= 1'b1;
              bus.SENSOR_FAIL <= 1'b0;
              retry_cnt       <= '0;
              cnt             <= '0;
              state           <= WAIT_PERIOD;
            end else begin
              bus.CRC_ERR <= 1'b1;
            end
          end
          RETRY_GAP: begin
            if (cnt == CNT_W'(RETRY_GAP_CYC - 1)) begin
              cnt           <= '0;
              state         <= START;
              bus.RDR_START <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (fail) begin
          if (bus.ERR_CNT != 8'hFF) bus.ERR_CNT <= bus.ERR_CNT + 1'b1;
          cnt <= '0;
          if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 1'b1;
            state     <= RETRY_GAP;
          end else begin
            bus.SENSOR_FAIL <= 1'b1;
            bus.DATA_VALID  <= 1'b0;
            retry_cnt       <= '0;
            state           <= WAIT_PERIOD;
          end
        end
      end
    end
  end
endmodule
